// File: rtl/get_pkg.sv
// Shared types and helpers for the get-side controller of the cell-based FIFO:
// output state encoding, one-hot token rotation and one-hot to index conversion.
package get_pkg;

    localparam int MAX_CELLS = 64;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Rotate a one-hot token left by one within an n-cell ring (bit n-1 wraps to bit 0).
    function automatic logic [MAX_CELLS-1:0] token_rotate(input logic [MAX_CELLS-1:0] tok,
                                                          input int n);
        logic [MAX_CELLS-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_CELLS - 1; i++) begin
            if (i < n - 1) r[i+1] = tok[i];
        end
        for (int i = 0; i < MAX_CELLS; i++) begin
            if (i == n - 1) r[0] = tok[i];
        end
        return r;
    endfunction

    function automatic int onehot_idx(input logic [MAX_CELLS-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_CELLS; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/get_controller_head_token_ring.sv
// One-hot head token for the get side: resets to cell 0 and moves one cell
// forward (with wrap) on each cycle that advance is high.
module head_token_ring
    import get_pkg::*;
#(
    parameter int N_CELLS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               advance,
    output logic [N_CELLS-1:0] token
);

    always_ff @(posedge clk) begin
        if (reset) begin
            token <= N_CELLS'(1);
        end else if (advance) begin
            token <= N_CELLS'(token_rotate(MAX_CELLS'(token), N_CELLS));
        end
    end

endmodule

// File: rtl/get_controller.sv
// Read-side controller of the cell-based FIFO: pulls the head cell into one output
// register behind a valid/ready handshake. Optional build macro GET_CONTROLLER_OCC_CNT_EN.
module get_controller
    import get_pkg::*;
#(
    parameter int N_CELLS    = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_CELLS-1:0]            f_i,
    input  logic [N_CELLS*DATA_WIDTH-1:0] d_i,
    output logic [N_CELLS-1:0]            get_o,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          empty
`ifdef GET_CONTROLLER_OCC_CNT_EN
    ,
    output logic [$clog2(N_CELLS+1):0]    occ_o,
    output logic                          order_err_o
`endif
);

    localparam int IDX_W = $clog2(N_CELLS);

    out_state_e             state;
    out_state_e             state_next;
    logic [N_CELLS-1:0]     token;
    logic                   head_full;
    logic                   take;
    logic                   valid_next;
    logic [IDX_W-1:0]       head_idx;
    logic [DATA_WIDTH-1:0]  head_word;

    head_token_ring #(
        .N_CELLS (N_CELLS)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .advance (take),
        .token   (token)
    );

    assign valid_o = (state == OUT_FULL);

    // A read happens whenever the head cell is full and the output register is free
    // or being drained this cycle; that is what gives one word per cycle when streaming.
    always_comb begin
        head_full  = |(f_i & token);
        take       = head_full && ((state == OUT_EMPTY) || ready_i);
        state_next = state;
        case (state)
            OUT_EMPTY: if (take) state_next = OUT_FULL;
            OUT_FULL:  if (ready_i && !take) state_next = OUT_EMPTY;
            default:   state_next = OUT_EMPTY;
        endcase
        valid_next = (state_next == OUT_FULL);
    end

    always_comb begin
        head_idx  = IDX_W'(onehot_idx(MAX_CELLS'(token)));
        head_word = '0;
        for (int k = 0; k < N_CELLS; k++) begin
            if (head_idx == IDX_W'(k)) head_word = d_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= OUT_EMPTY;
            data_o <= '0;
            get_o  <= '0;
            empty  <= 1'b1;
        end else begin
            state <= state_next;
            get_o <= take ? token : '0;
            if (take) data_o <= head_word;
            empty <= !(valid_next || (|f_i));
        end
    end

`ifdef GET_CONTROLLER_OCC_CNT_EN
    localparam int OCC_W = $clog2(N_CELLS+1) + 1;

    logic [OCC_W-1:0] f_count;

    always_comb begin
        f_count = '0;
        for (int k = 0; k < N_CELLS; k++) begin
            f_count = f_count + OCC_W'(f_i[k]);
        end
    end

    // Any full cell while the head is empty and nothing is held means the put side skipped a cell.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_o       <= '0;
            order_err_o <= 1'b0;
        end else begin
            occ_o <= f_count + OCC_W'(valid_o);
            if ((|f_i) && !head_full && (state == OUT_EMPTY)) order_err_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_get_controller.sv
// Directed bench for get_controller with a behavioural cell array that clears a
// cell's flag on the edge after its get strobe.
module tb_get_controller;

    localparam int N  = 16;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    f_i;
    logic [N*DW-1:0] d_i;
    logic [N-1:0]    get_o;
    logic [DW-1:0]   data_o;
    logic            valid_o;
    logic            ready_i;
    logic            empty;
`ifdef GET_CONTROLLER_OCC_CNT_EN
    logic [$clog2(N+1):0] occ_o;
    logic                 order_err_o;
`endif

    logic [N-1:0]  cells_f;
    logic [N-1:0]  pend;
    logic [DW-1:0] cell_d [N];
    int            n_checks;
    int            n_fail;

    always #5 clk = ~clk;

    get_controller #(
        .N_CELLS    (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .f_i         (f_i),
        .d_i         (d_i),
        .get_o       (get_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .empty       (empty)
`ifdef GET_CONTROLLER_OCC_CNT_EN
        ,
        .occ_o       (occ_o),
        .order_err_o (order_err_o)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply();
        f_i = cells_f;
        for (int k = 0; k < N; k++) d_i[k*DW +: DW] = cell_d[k];
    endtask

    task automatic tick();
        apply();
        @(posedge clk);
        #1;
        cells_f = cells_f & ~pend;
        pend    = get_o;
        apply();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pend     = '0;
        cells_f  = 16'h0001;
        for (int k = 0; k < N; k++) cell_d[k] = '0;
        reset   = 1'b1;
        ready_i = 1'b0;
        tick();
        tick();
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_get", 64'(get_o), 64'd0);
        check("rst_data", 64'(data_o), 64'd0);

        cells_f = '0;
        reset   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_empty", 64'(empty), 64'd1);
            check("idle_valid", 64'(valid_o), 64'd0);
            check("idle_get", 64'(get_o), 64'd0);
        end

        cell_d[0]  = 8'hA5;
        cells_f[0] = 1'b1;
        tick();
        check("single_valid", 64'(valid_o), 64'd1);
        check("single_data", 64'(data_o), 64'hA5);
        check("single_get", 64'(get_o), 64'h0001);
        check("single_empty", 64'(empty), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 64'(valid_o), 64'd1);
            check("stall_data", 64'(data_o), 64'hA5);
            check("stall_get", 64'(get_o), 64'd0);
        end
        ready_i = 1'b1;
        tick();
        check("drain_valid", 64'(valid_o), 64'd0);
        check("drain_empty", 64'(empty), 64'd1);
        check("drain_data_kept", 64'(data_o), 64'hA5);

        ready_i    = 1'b0;
        cell_d[1]  = 8'h3C;
        cells_f[1] = 1'b1;
        tick();
        check("mid_valid", 64'(valid_o), 64'd1);
        check("mid_data", 64'(data_o), 64'h3C);
        check("mid_get", 64'(get_o), 64'h0002);
        reset = 1'b1;
        tick();
        check("midrst_valid", 64'(valid_o), 64'd0);
        check("midrst_get", 64'(get_o), 64'd0);
        check("midrst_data", 64'(data_o), 64'd0);
        check("midrst_empty", 64'(empty), 64'd1);
        reset = 1'b0;

        for (int k = 0; k < N; k++) cell_d[k] = 8'(8'h10 + k);
        cells_f = '1;
        ready_i = 1'b1;
        for (int i = 0; i < N; i++) begin
            tick();
            check("stream_valid", 64'(valid_o), 64'd1);
            check("stream_data", 64'(data_o), 64'(8'h10 + i));
            check("stream_get", 64'(get_o), 64'(16'h0001 << i));
        end
        tick();
        check("stream_end_valid", 64'(valid_o), 64'd0);
        check("stream_end_get", 64'(get_o), 64'd0);
        tick();
        check("stream_end_empty", 64'(empty), 64'd1);

        cell_d[1]  = 8'h55;
        cells_f[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("skip_valid", 64'(valid_o), 64'd0);
            check("skip_get", 64'(get_o), 64'd0);
        end
        check("skip_empty", 64'(empty), 64'd0);
`ifdef GET_CONTROLLER_OCC_CNT_EN
        check("order_err_set", 64'(order_err_o), 64'd1);
`endif
        cell_d[0]  = 8'h77;
        cells_f[0] = 1'b1;
        ready_i    = 1'b0;
        tick();
        check("wrap_valid", 64'(valid_o), 64'd1);
        check("wrap_data", 64'(data_o), 64'h77);
        check("wrap_get", 64'(get_o), 64'h0001);
        ready_i = 1'b1;
        tick();
        check("refill_data", 64'(data_o), 64'h55);
        check("refill_get", 64'(get_o), 64'h0002);
        check("refill_valid", 64'(valid_o), 64'd1);
        tick();
        check("refill_end_valid", 64'(valid_o), 64'd0);
        check("refill_end_data", 64'(data_o), 64'h55);

        for (int k = 0; k < 4; k++) cell_d[2+k] = 8'(8'hC0 + k);
        cells_f = cells_f | 16'h003C;
        ready_i = 1'b0;
        tick();
        check("bp_first_data", 64'(data_o), 64'hC0);
        check("bp_first_get", 64'(get_o), 64'h0004);
        for (int j = 1; j < 4; j++) begin
            ready_i = 1'b1;
            tick();
            check("bp_take_data", 64'(data_o), 64'(8'hC0 + j));
            check("bp_take_get", 64'(get_o), 64'(16'h0004 << j));
            check("bp_take_valid", 64'(valid_o), 64'd1);
            ready_i = 1'b0;
            tick();
            check("bp_hold_data", 64'(data_o), 64'(8'hC0 + j));
            check("bp_hold_get", 64'(get_o), 64'd0);
            check("bp_hold_valid", 64'(valid_o), 64'd1);
        end
        ready_i = 1'b1;
        tick();
        check("bp_end_valid", 64'(valid_o), 64'd0);
        check("bp_end_get", 64'(get_o), 64'd0);

`ifdef GET_CONTROLLER_OCC_CNT_EN
        for (int k = 0; k < 4; k++) cell_d[6+k] = 8'(8'hD0 + k);
        cells_f = cells_f | 16'h03C0;
        ready_i = 1'b0;
        tick();
        tick();
        tick();
        check("occ_data", 64'(data_o), 64'hD0);
        check("occ_count", 64'(occ_o), 64'd4);
        check("order_err_sticky", 64'(order_err_o), 64'd1);
        reset = 1'b1;
        tick();
        check("occ_rst", 64'(occ_o), 64'd0);
        check("order_err_rst", 64'(order_err_o), 64'd0);
`else
        reset = 1'b1;
        tick();
`endif
        check("final_rst_valid", 64'(valid_o), 64'd0);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
